// File: rtl/slv_guard_recovery_ctrl.sv
// Register-port sequencer for slv_guard_top: programs budgets and enable, then recovers on irq.
// Optional retry limit (LOCKED state, fatal_o) is enabled by SLV_GUARD_RECOVERY_RETRY_LIMIT_EN.
module slv_guard_recovery_ctrl #(
    parameter int unsigned AddrWidth   = 32,
    parameter logic [31:0] EnaOffset   = 32'h0,
    parameter logic [31:0] WrBudOffset = 32'h4,
    parameter logic [31:0] RdBudOffset = 32'h8,
    parameter logic [31:0] StatOffset  = 32'hC,
    parameter int unsigned RstTimeout  = 1024,
    parameter int unsigned MaxRetries  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [31:0]          wr_budget_i,
    input  logic [31:0]          rd_budget_i,
    output logic [AddrWidth-1:0] reg_addr_o,
    output logic [31:0]          reg_wdata_o,
    output logic [3:0]           reg_wstrb_o,
    output logic                 reg_write_o,
    output logic                 reg_valid_o,
    input  logic [31:0]          reg_rdata_i,
    input  logic                 reg_error_i,
    input  logic                 reg_ready_i,
    input  logic                 guard_irq_i,
    output logic                 rst_req_o,
    input  logic                 rst_stat_i,
    output logic [31:0]          status_o,
    output logic [7:0]           recov_cnt_o,
    output logic                 cfg_err_o,
    output logic                 rst_tmo_o,
    output logic                 busy_o,
    output logic                 fatal_o
);

    localparam int unsigned TmoW = $clog2(RstTimeout + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(RstTimeout - 1);

`ifdef SLV_GUARD_RECOVERY_RETRY_LIMIT_EN
    localparam logic [7:0] RetryLimit = 8'(MaxRetries);
`else
    // MaxRetries only has meaning when the retry limit is compiled in.
    if (MaxRetries > 255) begin : g_retry_limit_unused
    end
`endif

    typedef enum logic [3:0] {
        StCfgWbud,
        StCfgRbud,
        StCfgEna,
        StMonitor,
        StRdStat,
        StClrStat,
        StRstAssert,
        StRstRelease
`ifdef SLV_GUARD_RECOVERY_RETRY_LIMIT_EN
        , StLocked
`endif
    } state_e;

    state_e state_q, state_d;

    logic                 valid_q, valid_d;
    logic                 write_q, write_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [31:0]          status_q, status_d;
    logic [7:0]           recov_q, recov_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 rst_tmo_q, rst_tmo_d;
    logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;

    logic bus_state;
    logic accept;
    logic tmo_hit;

    assign bus_state = state_q inside {StCfgWbud, StCfgRbud, StCfgEna, StRdStat, StClrStat};
    assign accept    = valid_q & reg_ready_i;
    assign tmo_hit   = (tmo_cnt_q == TmoLast);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StCfgWbud;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCfgWbud:    if (accept) state_d = StCfgRbud;
            StCfgRbud:    if (accept) state_d = StCfgEna;
            StCfgEna:     if (accept) state_d = StMonitor;
            StMonitor: begin
                if (guard_irq_i) begin
`ifdef SLV_GUARD_RECOVERY_RETRY_LIMIT_EN
                    state_d = (recov_q == RetryLimit) ? StLocked : StRdStat;
`else
                    state_d = StRdStat;
`endif
                end
            end
            StRdStat:     if (accept) state_d = StClrStat;
            StClrStat:    if (accept) state_d = StRstAssert;
            StRstAssert:  if (rst_stat_i || tmo_hit) state_d = StRstRelease;
            StRstRelease: if (!rst_stat_i || tmo_hit) state_d = StCfgWbud;
`ifdef SLV_GUARD_RECOVERY_RETRY_LIMIT_EN
            StLocked:     state_d = StLocked;
`endif
            default:      state_d = StCfgWbud;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy_o    = (state_q != StMonitor);
        rst_req_o = (state_q == StRstAssert);
        fatal_o   = 1'b0;
`ifdef SLV_GUARD_RECOVERY_RETRY_LIMIT_EN
        if (state_q == StLocked) begin
            rst_req_o = 1'b1;
            fatal_o   = 1'b1;
        end
`endif
    end

    // Bus request, captured status, counters and sticky flags
    always_comb begin
        valid_d   = valid_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        status_d  = status_q;
        recov_d   = recov_q;
        cfg_err_d = cfg_err_q;
        rst_tmo_d = rst_tmo_q;
        tmo_cnt_d = tmo_cnt_q;

        // Request launches one cycle after entering a bus state; payload sampled here.
        if (bus_state && !valid_q) begin
            valid_d = 1'b1;
            unique case (state_q)
                StCfgWbud: begin
                    write_d = 1'b1;
                    addr_d  = AddrWidth'(WrBudOffset);
                    wdata_d = wr_budget_i;
                    wstrb_d = 4'hF;
                end
                StCfgRbud: begin
                    write_d = 1'b1;
                    addr_d  = AddrWidth'(RdBudOffset);
                    wdata_d = rd_budget_i;
                    wstrb_d = 4'hF;
                end
                StCfgEna: begin
                    write_d = 1'b1;
                    addr_d  = AddrWidth'(EnaOffset);
                    wdata_d = 32'h1;
                    wstrb_d = 4'h1;
                end
                StRdStat: begin
                    write_d = 1'b0;
                    addr_d  = AddrWidth'(StatOffset);
                    wdata_d = 32'h0;
                    wstrb_d = 4'h0;
                end
                StClrStat: begin
                    write_d = 1'b1;
                    addr_d  = AddrWidth'(StatOffset);
                    wdata_d = status_q;
                    wstrb_d = 4'hF;
                end
                default: ;
            endcase
        end

        if (accept) begin
            valid_d = 1'b0;
            write_d = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            wstrb_d = '0;
            if (state_q == StRdStat) begin
                status_d = reg_rdata_i;
            end
            if (reg_error_i) begin
                cfg_err_d = 1'b1;
            end
        end

        if (state_d != state_q) begin
            tmo_cnt_d = '0;
        end else if (state_q inside {StRstAssert, StRstRelease}) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        if (tmo_hit && ((state_q == StRstAssert && !rst_stat_i) ||
                        (state_q == StRstRelease && rst_stat_i))) begin
            rst_tmo_d = 1'b1;
        end

        if (state_q == StRstRelease && state_d == StCfgWbud && recov_q != 8'hFF) begin
            recov_d = recov_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            status_q  <= '0;
            recov_q   <= '0;
            cfg_err_q <= 1'b0;
            rst_tmo_q <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            status_q  <= status_d;
            recov_q   <= recov_d;
            cfg_err_q <= cfg_err_d;
            rst_tmo_q <= rst_tmo_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign reg_valid_o = valid_q;
    assign reg_write_o = write_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wstrb_o = wstrb_q;
    assign status_o    = status_q;
    assign recov_cnt_o = recov_q;
    assign cfg_err_o   = cfg_err_q;
    assign rst_tmo_o   = rst_tmo_q;

endmodule

// File: tb/tb_slv_guard_recovery_ctrl.sv
// Scoreboard bench for slv_guard_recovery_ctrl: expected bus transactions queued by the
// stimulus, popped and compared by a monitor on each accepted request.
module tb_slv_guard_recovery_ctrl;

    localparam int unsigned TbMaxRetries = 2;
    localparam int unsigned TbTimeout    = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wr_budget_i = 32'd1;
    logic [31:0] rd_budget_i = 32'd1;
    logic [31:0] reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_wstrb_o;
    logic        reg_write_o;
    logic        reg_valid_o;
    logic [31:0] reg_rdata_i;
    logic        reg_error_i;
    logic        reg_ready_i;
    logic        guard_irq_i = 1'b0;
    logic        rst_req_o;
    logic        rst_stat_i;
    logic [31:0] status_o;
    logic [7:0]  recov_cnt_o;
    logic        cfg_err_o;
    logic        rst_tmo_o;
    logic        busy_o;
    logic        fatal_o;

    slv_guard_recovery_ctrl #(
        .RstTimeout (TbTimeout),
        .MaxRetries (TbMaxRetries)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wr_budget_i (wr_budget_i),
        .rd_budget_i (rd_budget_i),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_wstrb_o (reg_wstrb_o),
        .reg_write_o (reg_write_o),
        .reg_valid_o (reg_valid_o),
        .reg_rdata_i (reg_rdata_i),
        .reg_error_i (reg_error_i),
        .reg_ready_i (reg_ready_i),
        .guard_irq_i (guard_irq_i),
        .rst_req_o   (rst_req_o),
        .rst_stat_i  (rst_stat_i),
        .status_o    (status_o),
        .recov_cnt_o (recov_cnt_o),
        .cfg_err_o   (cfg_err_o),
        .rst_tmo_o   (rst_tmo_o),
        .busy_o      (busy_o),
        .fatal_o     (fatal_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;
    bit   err_en = 1'b0;
    bit   stat_stuck = 1'b0;
    logic [31:0] rdata_val = '0;
    int   req_hi_total = 0;
    int   model_recov = 0;
    logic [31:0] model_status = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: a configuration pass and a recovery in terms of bus transactions.
    task automatic push_cfg(input logic [31:0] wb, input logic [31:0] rb);
        exp_q.push_back('{write: 1'b1, addr: 32'h4, wdata: wb, wstrb: 4'hF});
        exp_q.push_back('{write: 1'b1, addr: 32'h8, wdata: rb, wstrb: 4'hF});
        exp_q.push_back('{write: 1'b1, addr: 32'h0, wdata: 32'h1, wstrb: 4'h1});
    endtask

    task automatic push_recovery(input logic [31:0] st);
        exp_q.push_back('{write: 1'b0, addr: 32'hC, wdata: 32'h0, wstrb: 4'h0});
        exp_q.push_back('{write: 1'b1, addr: 32'hC, wdata: st, wstrb: 4'hF});
        model_status = st;
    endtask

    // Slave and subordinate-reset models, driven just after each rising edge.
    initial begin
        int cyc = 0;
        logic [2:0] lag = '0;
        reg_ready_i = 1'b1;
        reg_error_i = 1'b0;
        reg_rdata_i = '0;
        rst_stat_i  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            reg_ready_i = (ready_mode == 0) ? 1'b1 : (cyc % 5 == 0);
            reg_rdata_i = rdata_val;
            reg_error_i = err_en && reg_valid_o && reg_write_o && (reg_addr_o == 32'h8);
            rst_stat_i  = stat_stuck ? 1'b0 : lag[2];
            lag = {lag[1:0], rst_req_o};
        end
    end

    // Monitor: pops the scoreboard on accepted requests and checks hold during waits.
    initial begin
        bit   pend = 1'b0;
        txn_t held;
        txn_t act;
        txn_t e;
        forever begin
            @(negedge clk);
            if (rst_req_o === 1'b1) req_hi_total++;
            if (rst_n !== 1'b1) begin
                pend = 1'b0;
            end else begin
                act.write = reg_write_o;
                act.addr  = reg_addr_o;
                act.wdata = reg_wdata_o;
                act.wstrb = reg_wstrb_o;
                if (pend) begin
                    checks++;
                    if (reg_valid_o !== 1'b1 || act !== held) begin
                        errors++;
                        $display("FAIL hold: got valid=%b %h, expected valid=1 %h",
                                 reg_valid_o, act, held);
                    end
                end
                if (reg_valid_o === 1'b1 && reg_ready_i === 1'b1) begin
                    pend = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL txn: got unexpected %h, expected none", act);
                    end else begin
                        e = exp_q.pop_front();
                        if (act.write !== e.write || act.addr !== e.addr ||
                            (e.write && (act.wdata !== e.wdata || act.wstrb !== e.wstrb))) begin
                            errors++;
                            $display("FAIL txn: got %h, expected %h", act, e);
                        end
                    end
                end else if (reg_valid_o === 1'b1) begin
                    pend = 1'b1;
                    held = act;
                end else begin
                    pend = 1'b0;
                end
            end
        end
    end

    task automatic pulse_irq();
        @(posedge clk);
        #1 guard_irq_i = 1'b1;
        @(posedge clk);
        #1 guard_irq_i = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while (busy_o !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: got busy=%b after %0d cycles, expected 0", name, busy_o, bound);
        end
    endtask

    task automatic do_recovery(input logic [31:0] st, input int bound, input string name);
        logic [31:0] wb;
        logic [31:0] rb;
        wb = $urandom;
        rb = $urandom;
        rdata_val   = st;
        wr_budget_i = wb;
        rd_budget_i = rb;
        push_recovery(st);
        push_cfg(wb, rb);
        pulse_irq();
        wait_idle(bound, name);
        model_recov = (model_recov < 255) ? model_recov + 1 : 255;
    endtask

    initial begin
        int r0;
        int n;
        logic [31:0] st;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy_o, 1);
        check("rst_valid", reg_valid_o, 0);
        check("rst_addr", reg_addr_o, 0);
        check("rst_req", rst_req_o, 0);
        check("rst_status", status_o, 0);
        check("rst_recov", recov_cnt_o, 0);
        check("rst_flags", {cfg_err_o, rst_tmo_o, fatal_o}, 0);

        // Power-up configuration, zero-wait slave
        push_cfg(32'd1, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("busy_cycle5", busy_o, 1);
        @(posedge clk);
        @(negedge clk);
        check("monitor_cycle6", busy_o, 0);
        repeat (5) @(negedge clk);
        check("monitor_stays", busy_o, 0);
        check("cfg_drained", exp_q.size(), 0);

        // Interrupt recovery with 3-cycle acknowledge lag
        r0 = req_hi_total;
        do_recovery(32'h3, 200, "recovery_idle");
        check("req_high_cycles", req_hi_total - r0, 4);
        check("status_3", status_o, 32'h3);
        check("recov_1", recov_cnt_o, model_recov);
        check("recovery_drained", exp_q.size(), 0);

        // Reset asserted during RST_ASSERT
        stat_stuck = 1'b1;
        st = $urandom | 32'h1;
        rdata_val = st;
        push_recovery(st);
        pulse_irq();
        n = 0;
        while (rst_req_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_rise", rst_req_o, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_recov = 0;
        check("midrst_req", rst_req_o, 0);
        check("midrst_valid", reg_valid_o, 0);
        check("midrst_status", status_o, 0);
        check("midrst_recov", recov_cnt_o, model_recov);
        check("midrst_flags", {cfg_err_o, rst_tmo_o, fatal_o}, 0);
        check("midrst_busy", busy_o, 1);
        check("midrst_drained", exp_q.size(), 0);
        stat_stuck = 1'b0;
        wr_budget_i = $urandom;
        rd_budget_i = $urandom;
        push_cfg(wr_budget_i, rd_budget_i);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle(50, "restart_idle");
        check("restart_drained", exp_q.size(), 0);

        // Wait-state slave: ready every 5th cycle
        ready_mode = 1;
        do_recovery($urandom, 500, "wait_idle");
        check("wait_status", status_o, model_status);
        check("wait_recov", recov_cnt_o, model_recov);
        check("wait_drained", exp_q.size(), 0);
        ready_mode = 0;

        // Bus error on 0x8 write and reset acknowledge that never arrives
        err_en = 1'b1;
        stat_stuck = 1'b1;
        r0 = req_hi_total;
        do_recovery($urandom, 2000, "tmo_idle");
        check("cfg_err", cfg_err_o, 1);
        check("rst_tmo", rst_tmo_o, 1);
        check("tmo_req_cycles", req_hi_total - r0, TbTimeout);
        check("tmo_recov", recov_cnt_o, model_recov);
        check("tmo_drained", exp_q.size(), 0);
        err_en = 1'b0;
        stat_stuck = 1'b0;

`ifdef SLV_GUARD_RECOVERY_RETRY_LIMIT_EN
        // Two recoveries done since reset: the next interrupt locks the sequencer
        pulse_irq();
        repeat (3) @(negedge clk);
        check("lock_fatal", fatal_o, 1);
        check("lock_req", rst_req_o, 1);
        check("lock_busy", busy_o, 1);
        check("lock_valid", reg_valid_o, 0);
        repeat (20) @(negedge clk);
        check("lock_holds", {fatal_o, rst_req_o}, 2'b11);
        check("lock_recov", recov_cnt_o, model_recov);
`else
        // Counter saturation
        for (int i = 0; i < 256; i++) begin
            do_recovery($urandom, 200, "sat_idle");
        end
        check("sat_recov", recov_cnt_o, 8'd255);
        check("sat_fatal", fatal_o, 0);
        check("sat_drained", exp_q.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/slv_guard_recovery_ctrl.md
# slv_guard_recovery_ctrl

Sequencer that owns the register port of `slv_guard_top` and drives its reset handshake. After reset it programs the write budget, then the read budget, then the enable bit. It then watches `irq_o`. On an interrupt it reads and clears the guard status, resets the guarded subordinate through the `rst_req_o`/`rst_stat_i` handshake, and reprograms the guard. It sits between the SoC control logic and `slv_guard_top`, replacing the manual software configuration sequence.

## Interface
- `AddrWidth`, 32: register-bus address width.
- `EnaOffset`, 32'h0: guard enable register.
- `WrBudOffset`, 32'h4: write-budget register.
- `RdBudOffset`, 32'h8: read-budget register.
- `StatOffset`, 32'hC: irq status register; write-1-to-clear.
- `RstTimeout`, 1024: maximum cycles to wait on each reset-handshake edge.
- `MaxRetries`, 4: recovery limit; used only with the macro in Configuration.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset; synchronous, active-low.
- `wr_budget_i` in 32: write budget; sampled at each configuration pass.
- `rd_budget_i` in 32: read budget; sampled at each configuration pass.
- `reg_addr_o` out AddrWidth: register-bus address.
- `reg_wdata_o` out 32: register-bus write data.
- `reg_wstrb_o` out 4: register-bus byte strobes.
- `reg_write_o` out 1: 1 = write, 0 = read.
- `reg_valid_o` out 1: register-bus request valid.
- `reg_rdata_i` in 32: register-bus read data.
- `reg_error_i` in 1: register-bus error response.
- `reg_ready_i` in 1: register-bus ready.
- `guard_irq_i` in 1: guard `irq_o`.
- `rst_req_o` out 1: subordinate reset request; drives the guard `rst_stat_i` path.
- `rst_stat_i` in 1: subordinate reset acknowledge.
- `status_o` out 32: last status word read from the guard.
- `recov_cnt_o` out 8: completed recoveries; saturates at 255.
- `cfg_err_o` out 1: sticky register-bus error flag.
- `rst_tmo_o` out 1: sticky reset-handshake timeout flag.
- `busy_o` out 1: high in every state except MONITOR.
- `fatal_o` out 1: recovery limit reached.

## Operation
- **Reset values:** state = CFG_WBUD. All `reg_*_o`, `rst_req_o`, `status_o`, `recov_cnt_o`, `cfg_err_o`, `rst_tmo_o` and `fatal_o` are 0. `busy_o` = 1.
- **Configuration states:**
  - CFG_WBUD: write `wr_budget_i` to `WrBudOffset`, wstrb 4'hF.
  - CFG_RBUD: write `rd_budget_i` to `RdBudOffset`, wstrb 4'hF.
  - CFG_ENA: write 32'h1 to `EnaOffset`, wstrb 4'h1.
  - CFG_WBUD → CFG_RBUD → CFG_ENA → MONITOR.
- **MONITOR:** bus idle. `guard_irq_i` = 1 → RD_STAT.
- **RD_STAT:** read `StatOffset`; capture `reg_rdata_i` into `status_o` on the accepting cycle. → CLR_STAT.
- **CLR_STAT:** write `status_o` to `StatOffset`, wstrb 4'hF. → RST_ASSERT.
- **RST_ASSERT:** `rst_req_o` = 1 until `rst_stat_i` = 1. → RST_RELEASE.
- **RST_RELEASE:** `rst_req_o` = 0 until `rst_stat_i` = 0. Then increment `recov_cnt_o` and go to CFG_WBUD.
- **Bus errors:** `reg_error_i` high on an accepting cycle sets `cfg_err_o`. The sequence still advances; a failed transaction is never retried.
- **Timeout:** each of RST_ASSERT and RST_RELEASE has its own cycle counter. Reaching `RstTimeout` sets `rst_tmo_o`, drops `rst_req_o` and forces the next state (RST_RELEASE, then CFG_WBUD).
- **Interrupts outside MONITOR:** `guard_irq_i` is ignored. If irq is still high on return to MONITOR, recovery restarts the next cycle.

## Timing
- **Request assertion:** `reg_valid_o` and its payload rise one cycle after entering a bus state.
- **Request hold:** valid and payload are stable until a cycle with `reg_ready_i` = 1, the accepting cycle.
- **Release:** valid drops the cycle after acceptance, together with the state advance. Back-to-back transactions therefore have one idle cycle between them.
- **Zero-wait slave:** with `reg_ready_i` tied high, the three-write configuration reaches MONITOR 6 cycles after reset release.
- **Read data:** `status_o` updates on the clock edge of the accepting cycle.
- **Interrupt latency:**
  - `guard_irq_i` sampled high in MONITOR → RD_STAT valid 2 cycles later.
  - `rst_req_o` rises 1 cycle after CLR_STAT acceptance.
- **Reset mid-transaction:** `rst_ni` low aborts any transaction. `reg_valid_o` is 0 on the next edge and the full configuration restarts.
- **Counter wrap:** `recov_cnt_o` saturates at 255 and never wraps.

## Configuration
- **Macro:** `SLV_GUARD_RECOVERY_RETRY_LIMIT_EN`.
- **Defined:**
  - An interrupt in MONITOR when `recov_cnt_o` == `MaxRetries` enters LOCKED instead of RD_STAT.
  - LOCKED: `fatal_o` = 1, bus idle, `rst_req_o` = 1. It is left only by `rst_ni`.
- **Undefined:** recovery is unlimited, LOCKED does not exist, `fatal_o` is tied 0 and `MaxRetries` is unused.

## Test plan
- **Power-up configuration:** `wr_budget_i` = 1, `rd_budget_i` = 1, zero-wait slave.
  - Writes appear in order: 0x4/1/F, 0x8/1/F, 0x0/1/1.
  - MONITOR is reached at cycle 6.
  - `busy_o` = 0 from then on.
- **Interrupt recovery:** pulse irq; slave returns 32'h0000_0003; `rst_stat_i` follows `rst_req_o` with 3-cycle lag.
  - `status_o` = 3.
  - 0xC is written with 3.
  - `rst_req_o` is high for 4 cycles.
  - `recov_cnt_o` = 1, followed by a full reconfiguration.
- **Wait-state slave:** `reg_ready_i` asserted every 5th cycle.
  - Valid and payload stay stable through every wait cycle.
  - No transaction is dropped or duplicated.
- **Error and timeout:** error on the 0x8 write, and `rst_stat_i` held 0 during recovery.
  - `cfg_err_o` = 1 and the sequence continues.
  - `rst_tmo_o` = 1 after 1024 cycles.
  - Reconfiguration still occurs.
- **Reset mid-operation:** `rst_ni` low during RST_ASSERT.
  - `rst_req_o` is 0 and all flags are 0 the next cycle.
  - Configuration restarts.
- **Retry limit (macro defined, `MaxRetries` = 2):** three interrupts.
  - Two recoveries complete.
  - The third enters LOCKED with `fatal_o` = 1 and `rst_req_o` = 1.
